// File: rtl/uart_pkg.sv
// Shared UART definitions: the oversample factor, the TX/RX state encodings
// and the parity helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // even = 1 means the frame's total count of ones, parity bit included, is even
    function automatic logic parity_bit(input logic data_xor, input logic even);
        return even ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: o_tick pulses one clock every SYS_CLK/(BAUD_RATE*16) clocks.
// A low i_en freezes the count, so the tick phase survives a pause.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int SYS_CLK   = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int DIV_RAW = SYS_CLK / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);
    assign o_tick = i_en & w_wrap;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_top_module.sv
// Full-duplex UART: one shared 16x tick, independent TX and RX state machines.
// Parity bits are supported only when UART_PARITY_EN is defined.
module uart_top_module
    import uart_pkg::*;
#(
    parameter int SYS_CLK    = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  baud_gen_en,
    input  logic                  parity_en,
    input  logic                  odd_r_even_parity,
    input  logic                  rx,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic                  framing_error,
    output logic                  parity_error,
    output logic [DATA_WIDTH-1:0] data_out
);

`ifdef UART_PARITY_EN
    localparam bit PARITY_BUILD = 1'b1;
`else
    localparam bit PARITY_BUILD = 1'b0;
`endif

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]      LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [TICK_W-1:0]     LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0]     HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DATA_WIDTH-1:0] MSB_MASK  = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

    logic w_tick;
    logic w_par_en;

    assign w_par_en = parity_en & PARITY_BUILD;

    uart_baud_gen #(
        .SYS_CLK   (SYS_CLK),
        .BAUD_RATE (BAUD_RATE)
    ) u_baud_gen (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (baud_gen_en),
        .o_tick (w_tick)
    );

    tx_state_t             r_tx_state;
    logic [TICK_W-1:0]     r_tx_tick;
    logic [BIT_W-1:0]      r_tx_bit;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_tx_par_en;
    logic                  r_tx_par_bit;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_tx_idle_ok;
    logic                  w_tx_bit_end;
    logic [DATA_WIDTH-1:0] w_tx_shift_nx;

    assign w_tx_bit_end  = w_tick && (r_tx_tick == LAST_TICK);
    assign w_tx_shift_nx = r_tx_shift >> 1;
    assign tx            = r_tx;
    assign busy          = r_busy;

    // r_tx_idle_ok forces at least one tick of idle line between back-to-back frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state   <= TX_IDLE;
            r_tx_tick    <= '0;
            r_tx_bit     <= '0;
            r_tx_shift   <= '0;
            r_tx_par_en  <= 1'b0;
            r_tx_par_bit <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_tx_idle_ok <= 1'b1;
        end else begin
            if (w_tick && r_tx_state != TX_IDLE) begin
                r_tx_tick <= r_tx_tick + TICK_W'(1);
            end
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tick) begin
                        r_tx_idle_ok <= 1'b1;
                    end
                    if (tx_en && baud_gen_en && r_tx_idle_ok) begin
                        r_tx_state   <= TX_START;
                        r_tx_shift   <= data_in;
                        r_tx_par_en  <= w_par_en;
                        r_tx_par_bit <= parity_bit(^data_in, odd_r_even_parity);
                        r_tx_tick    <= '0;
                        r_tx_bit     <= '0;
                        r_tx         <= 1'b0;
                        r_busy       <= 1'b1;
                        r_tx_idle_ok <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_state <= TX_DATA;
                        r_tx       <= r_tx_shift[0];
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        if (r_tx_bit == LAST_BIT) begin
                            r_tx_bit <= '0;
                            if (r_tx_par_en) begin
                                r_tx_state <= TX_PARITY;
                                r_tx       <= r_tx_par_bit;
                            end else begin
                                r_tx_state <= TX_STOP;
                                r_tx       <= 1'b1;
                            end
                        end else begin
                            r_tx_bit   <= r_tx_bit + BIT_W'(1);
                            r_tx_shift <= w_tx_shift_nx;
                            r_tx       <= w_tx_shift_nx[0];
                        end
                    end
                end
                TX_PARITY: begin
                    if (w_tx_bit_end) begin
                        r_tx_state <= TX_STOP;
                        r_tx       <= 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_tx_bit_end) begin
                        r_tx_state <= TX_IDLE;
                        r_busy     <= 1'b0;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    logic                  r_rx_meta;
    logic                  r_rx_sync;
    rx_state_t             r_rx_state;
    logic [TICK_W-1:0]     r_rx_tick;
    logic [BIT_W-1:0]      r_rx_bit;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic                  r_rx_par_en;
    logic                  r_rx_par_even;
    logic                  r_rx_par_bit;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_framing_error;
    logic                  r_parity_error;
    logic                  w_rx_bit_end;
    logic                  w_rx_par_exp;
    logic [DATA_WIDTH-1:0] w_rx_shift_nx;

    assign w_rx_bit_end  = w_tick && (r_rx_tick == LAST_TICK);
    assign w_rx_par_exp  = parity_bit(^r_rx_shift, r_rx_par_even);
    assign w_rx_shift_nx = (r_rx_shift >> 1) | (r_rx_sync ? MSB_MASK : '0);

    assign done          = r_done;
    assign data_out      = r_data_out;
    assign framing_error = r_framing_error;
    assign parity_error  = r_parity_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // START counts half a bit so every later sample lands at bit centre
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state      <= RX_IDLE;
            r_rx_tick       <= '0;
            r_rx_bit        <= '0;
            r_rx_shift      <= '0;
            r_rx_par_en     <= 1'b0;
            r_rx_par_even   <= 1'b0;
            r_rx_par_bit    <= 1'b0;
            r_done          <= 1'b0;
            r_data_out      <= '0;
            r_framing_error <= 1'b0;
            r_parity_error  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tick && r_rx_state != RX_IDLE) begin
                r_rx_tick <= r_rx_tick + TICK_W'(1);
            end
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_tick && !r_rx_sync) begin
                        r_rx_state    <= RX_START;
                        r_rx_tick     <= '0;
                        r_rx_bit      <= '0;
                        r_rx_par_en   <= w_par_en;
                        r_rx_par_even <= odd_r_even_parity;
                    end
                end
                RX_START: begin
                    if (w_tick && r_rx_tick == HALF_TICK) begin
                        r_rx_tick  <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_shift <= w_rx_shift_nx;
                        if (r_rx_bit == LAST_BIT) begin
                            r_rx_bit   <= '0;
                            r_rx_state <= r_rx_par_en ? RX_PARITY : RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + BIT_W'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (w_rx_bit_end) begin
                        r_rx_par_bit <= r_rx_sync;
                        r_rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (w_rx_bit_end) begin
                        r_data_out      <= r_rx_shift;
                        r_framing_error <= ~r_rx_sync;
                        r_parity_error  <= r_rx_par_en & (r_rx_par_bit ^ w_rx_par_exp);
                        r_done          <= 1'b1;
                        r_rx_state      <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_top_module.sv
// Bench for uart_top_module: loopback and directly driven frames, checked against
// a frame-level model (expected-receive queue plus a time-based line decoder).
module tb_uart_top_module;

    localparam int SYS_CLK = 1_600_000;
    localparam int BAUD    = 10_000;
    localparam int DW      = 8;
    localparam int DIV     = SYS_CLK / (BAUD * 16);
    localparam int BITC    = 16 * DIV;

`ifdef UART_PARITY_EN
    localparam bit P_BUILD = 1'b1;
`else
    localparam bit P_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_en = 1'b0;
    logic          baud_gen_en = 1'b0;
    logic          parity_en = 1'b0;
    logic          odd_r_even_parity = 1'b0;
    logic          rx_drv = 1'b1;
    logic          loop = 1'b1;
    logic          rx;
    logic [DW-1:0] data_in = '0;
    logic          tx, busy, done, framing_error, parity_error;
    logic [DW-1:0] data_out;

    assign rx = loop ? tx : rx_drv;

    uart_top_module #(
        .SYS_CLK    (SYS_CLK),
        .BAUD_RATE  (BAUD),
        .DATA_WIDTH (DW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .tx_en             (tx_en),
        .baud_gen_en       (baud_gen_en),
        .parity_en         (parity_en),
        .odd_r_even_parity (odd_r_even_parity),
        .rx                (rx),
        .data_in           (data_in),
        .tx                (tx),
        .busy              (busy),
        .done              (done),
        .framing_error     (framing_error),
        .parity_error      (parity_error),
        .data_out          (data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // parity bit derived by counting ones, independent of any XOR formulation
    function automatic logic model_par(input logic [DW-1:0] d, input logic even);
        int ones = 0;
        for (int i = 0; i < DW; i++) ones += int'(d[i]);
        return even ? logic'(ones % 2) : logic'((ones + 1) % 2);
    endfunction

    typedef struct packed {
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
    } rx_exp_t;

    rx_exp_t       exp_q[$];
    rx_exp_t       popped;
    logic [DW-1:0] exp_d = '0;
    logic          exp_pe = 1'b0;
    logic          exp_fe = 1'b0;
    logic          prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_d  = '0;
            exp_pe = 1'b0;
            exp_fe = 1'b0;
            chk("busy_in_reset", 32'(busy), 32'd0);
            chk("done_in_reset", 32'(done), 32'd0);
        end else if (done) begin
            chk("done_one_clock", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                chk("done_without_frame", 32'(done), 32'd0);
            end else begin
                popped = exp_q.pop_front();
                exp_d  = popped.d;
                exp_pe = popped.pe;
                exp_fe = popped.fe;
            end
        end
        chk("data_out", 32'(data_out), 32'(exp_d));
        chk("parity_error", 32'(parity_error), 32'(exp_pe));
        chk("framing_error", 32'(framing_error), 32'(exp_fe));
        if (!busy) chk("tx_idle_high", 32'(tx), 32'd1);
        prev_done = done;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 1000) begin
            wait_clks(1);
            n++;
        end
        chk("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic wait_rx_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * BITC) begin
            wait_clks(1);
            n++;
        end
        chk("rx_frame_received", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_loop(input logic [DW-1:0] d, input logic pen, input logic even,
                             input bit pause, output logic bit9);
        logic [DW-1:0] got;
        logic          frz;
        rx_exp_t       e;
        bit            has_par;
        int            rise_c, dur, nb, lo, hi, n;
        has_par = P_BUILD && pen;
        wait_clks(1);
        data_in = d;
        parity_en = pen;
        odd_r_even_parity = even;
        tx_en = 1'b1;
        wait_busy();
        rise_c = cyc;
        tx_en = 1'b0;
        e.d = d;
        e.pe = 1'b0;
        e.fe = 1'b0;
        exp_q.push_back(e);
        wait_clks(8 * DIV);
        chk("tx_start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < DW; i++) begin
            wait_clks(BITC);
            got[i] = tx;
            if (pause && i == 3) begin
                baud_gen_en = 1'b0;
                frz = tx;
                for (int k = 0; k < 1000; k++) begin
                    wait_clks(1);
                    chk("tx_frozen", 32'(tx), 32'(frz));
                end
                baud_gen_en = 1'b1;
            end
        end
        chk("tx_data", 32'(got), 32'(d));
        wait_clks(BITC);
        bit9 = tx;
        if (has_par) begin
            chk("tx_parity_bit", 32'(bit9), 32'(model_par(d, even)));
            wait_clks(BITC);
        end
        chk("tx_stop_bit", 32'(tx), 32'd1);
        n = 0;
        while (busy && n < 2 * BITC) begin
            wait_clks(1);
            n++;
        end
        chk("busy_fall", 32'(busy), 32'd0);
        dur = cyc - rise_c;
        nb  = has_par ? DW + 3 : DW + 2;
        lo  = nb * BITC - DIV + 1 + (pause ? 1000 : 0);
        hi  = nb * BITC + (pause ? 1000 : 0);
        checks++;
        if (dur < lo || dur > hi) begin
            errors++;
            $display("FAIL frame_len: got %0d clocks, required %0d..%0d", dur, lo, hi);
        end
        wait_rx_drain();
    endtask

    task automatic send_raw(input logic [DW-1:0] d, input logic par_line, input logic stop,
                            input logic exp_pe_in);
        rx_exp_t e;
        e.d = d;
        e.pe = exp_pe_in;
        e.fe = ~stop;
        exp_q.push_back(e);
        wait_clks(1);
        rx_drv = 1'b0;
        wait_clks(BITC);
        for (int i = 0; i < DW; i++) begin
            rx_drv = d[i];
            wait_clks(BITC);
        end
        if (P_BUILD && parity_en) begin
            rx_drv = par_line;
            wait_clks(BITC);
        end
        rx_drv = stop;
        wait_clks(stop ? BITC : 12 * DIV);
        rx_drv = 1'b1;
        wait_rx_drain();
        wait_clks(3 * BITC);
    endtask

    initial begin
        #400000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic pb;

    initial begin
        wait_clks(10);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_ferr", 32'(framing_error), 32'd0);
        chk("reset_perr", 32'(parity_error), 32'd0);
        rst = 1'b0;
        baud_gen_en = 1'b1;
        wait_clks(3 * DIV);

        send_loop(8'd40, 1'b1, 1'b1, 1'b0, pb);
        chk("lit_data_40", 32'(data_out), 32'd40);
        chk("lit_perr_40", 32'(parity_error), 32'd0);
        send_loop(8'd85, 1'b1, 1'b0, 1'b0, pb);
        chk("lit_bit9_85_odd", 32'(pb), 32'd1);
        chk("lit_data_85", 32'(data_out), 32'd85);
        send_loop(8'd123, 1'b0, 1'b1, 1'b0, pb);
        chk("lit_data_123", 32'(data_out), 32'd123);
        send_loop(8'h00, 1'b1, 1'b0, 1'b0, pb);
        send_loop(8'hFF, 1'b1, 1'b1, 1'b0, pb);
        send_loop(8'h3C, 1'b1, 1'b1, 1'b1, pb);
        chk("lit_data_3c_paused", 32'(data_out), 32'h3C);

        loop = 1'b0;
        parity_en = 1'b1;
        odd_r_even_parity = 1'b0;
        wait_clks(2 * BITC);
        send_raw(8'h55, 1'b0, 1'b1, P_BUILD);
        chk("lit_data_55", 32'(data_out), 32'h55);
        send_raw(8'h55, 1'b1, 1'b0, 1'b0);
        chk("lit_ferr_55", 32'(framing_error), 32'd1);
        send_raw(8'hA5, model_par(8'hA5, 1'b0), 1'b1, 1'b0);
        chk("lit_ferr_cleared", 32'(framing_error), 32'd0);

        loop = 1'b1;
        wait_clks(2 * BITC);
        data_in = 8'hA7;
        parity_en = 1'b0;
        tx_en = 1'b1;
        wait_busy();
        tx_en = 1'b0;
        wait_clks(5 * BITC);
        rst = 1'b1;
        #1;
        chk("midframe_rst_tx", 32'(tx), 32'd1);
        chk("midframe_rst_busy", 32'(busy), 32'd0);
        chk("midframe_rst_done", 32'(done), 32'd0);
        wait_clks(20);
        rst = 1'b0;
        wait_clks(2 * BITC);
        send_loop(8'hC3, 1'b0, 1'b1, 1'b0, pb);
        chk("lit_data_after_rst", 32'(data_out), 32'hC3);

        wait_clks(2 * BITC);
        chk("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_top_module.md
UART_TOP_MODULE -- requirements
Module: uart_top_module

Interface
REQ-001 SHALL have parameter SYS_CLK, default 100_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-004 SHALL have port clk  input  1  the single clock for TX, RX and baud generation.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tx_en  input  1  transmit request, sampled in TX IDLE.
REQ-007 SHALL have port baud_gen_en  input  1  baud tick enable; low freezes TX and RX.
REQ-008 SHALL have port parity_en  input  1  parity bit present in TX and RX frames.
REQ-009 SHALL have port odd_r_even_parity  input  1  0 = odd parity, 1 = even parity.
REQ-010 SHALL have port rx  input  1  serial receive line, asynchronous, idle high.
REQ-011 SHALL have port data_in  input  DATA_WIDTH  parallel transmit data.
REQ-012 SHALL have port tx  output  1  serial transmit line, idle high.
REQ-013 SHALL have port busy  output  1  transmitter frame in progress.
REQ-014 SHALL have port done  output  1  one-clock pulse when a received frame completes.
REQ-015 SHALL have port framing_error  output  1  last received stop bit sampled low.
REQ-016 SHALL have port parity_error  output  1  last received parity bit mismatched.
REQ-017 SHALL have port data_out  output  DATA_WIDTH  last received payload.

Function
REQ-018 SHALL generate a 16x oversample tick every DIV = SYS_CLK/(BAUD_RATE*16) clocks, integer division (651 at defaults), only while baud_gen_en = 1.
REQ-019 SHALL use frame format: start bit 0, DATA_WIDTH bits LSB first, optional parity bit, one stop bit 1; every bit lasts 16 ticks.
REQ-020 SHALL compute the parity bit as XOR of the data bits for even parity and its inverse for odd parity.
REQ-021 SHALL implement TX FSM IDLE -> START -> DATA -> PARITY (only if parity_en) -> STOP -> IDLE.
REQ-022 In TX IDLE with tx_en = 1 and baud_gen_en = 1, SHALL latch data_in, parity_en and odd_r_even_parity, enter START and assert busy on the next clock.
REQ-023 SHALL keep busy high from START through the end of STOP and deassert it on the clock TX returns to IDLE.
REQ-024 If tx_en is still high on return to IDLE, SHALL start a new frame after at least one tick in IDLE.
REQ-025 SHALL pass rx through a two-flop synchronizer before any use.
REQ-026 SHALL implement RX FSM IDLE -> START -> DATA -> PARITY (only if parity_en) -> STOP -> IDLE.
REQ-027 SHALL leave RX IDLE on a synchronized low; in START, 8 ticks later it SHALL go to DATA if the line is still low, else back to IDLE.
REQ-028 SHALL sample DATA, PARITY and STOP bits at 16-tick intervals, i.e. at bit centre.
REQ-029 At STOP sample SHALL update data_out, set parity_error (mismatch, 0 if parity disabled) and set framing_error (stop = 0), and pulse done for exactly one clock.
REQ-030 SHALL hold data_out and the error flags until the next done pulse.
REQ-031 SHALL hold FSM state, bit counters and tick counter with no change while baud_gen_en = 0.
REQ-032 SHALL run TX and RX fully independently, allowing full duplex and loopback of tx to rx.

Reset
REQ-033 On rst SHALL immediately set tx = 1, busy = 0, done = 0, framing_error = 0, parity_error = 0, data_out = 0, both FSMs to IDLE and all counters to 0.
REQ-034 Reset mid-frame SHALL abort the frame with no done pulse; the next frame after release SHALL be received correctly.

Configuration
REQ-035 With macro UART_PARITY_EN defined, SHALL support parity as specified; without it, SHALL ignore parity_en and odd_r_even_parity, never emit or expect a parity bit, and tie parity_error to 0.

Structure
REQ-036 SHALL place the TX/RX state enum typedefs and the oversample factor constant (16) in a shared package uart_pkg.
REQ-037 SHALL implement the tick divider as one sub-module, uart_baud_gen, instanced once and shared by TX and RX.

Verification
REQ-038 Loopback tx to rx, send 8'd40 with parity_en = 1 and even parity -> done pulses, data_out = 40, both error flags 0.
REQ-039 Loopback, send 8'd85 with odd parity -> data_out = 85, no errors; line shows parity bit = 1.
REQ-040 Loopback, send 8'd123 with parity_en = 0 -> data_out = 123, no errors; frame is 10 bits long (~104,160 clocks at defaults).
REQ-041 Drive rx directly with 8'h55 plus an even-parity bit while RX is configured for odd parity -> parity_error = 1; drive a stop bit of 0 -> framing_error = 1.
REQ-042 Drop baud_gen_en mid-frame for 1000 clocks, then restore -> tx level is frozen, the frame then completes and data is received correctly.
REQ-043 Assert rst mid-frame -> tx = 1 and busy = 0 immediately, no done pulse; the next frame after release is received correctly.
